// File: rtl/fadd_acc.sv
// fadd_acc: streaming signed fixed-point accumulator for the adaptive-filter
// tap-sum path. Terms are summed in a guard-extended register (WIDTH+GUARD
// bits). At end of sum the total is narrowed back to WIDTH bits and
// presented with an overflow flag; a sticky flag collects every overflow.
//
// Build option: define FADD_ACC_SAT_EN to saturate o_res on overflow.
// When it is not defined, o_res is the low WIDTH bits of the sum (wrap).
// o_ovr and o_ovr_sticky behave the same in both builds.
//
// Handshake: a transfer happens on a side exactly in the cycle where its
// valid and ready are both high at the rising edge. Input side: i_valid /
// o_ready, with o_ready = !o_valid || i_res_ready. Output side: o_valid /
// i_res_ready. While o_valid && !i_res_ready, o_res and o_ovr hold steady.
// A valid source holds its data until the transfer happens.
module fadd_acc #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15,
  parameter int LEN   = 8,
  parameter int GUARD = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_res,
  output logic                     o_ovr,
  input  logic                     i_res_ready,
  output logic                     o_ovr_sticky,
  output logic [$clog2(LEN+1)-1:0] o_cnt,
  output logic                     o_dbg_state
);

  localparam int AW = WIDTH + GUARD;
  localparam int CW = $clog2(LEN + 1);

  // ACC: no result is held. OUT: a result is presented on o_valid.
  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   sum;
  logic [CW-1:0]   cnt_inc;
  logic            accept;
  logic            eos;
  logic            in_range;
  logic            pos_ovr;
  logic            neg_ovr;
  logic [WIDTH-1:0] narrow;

  assign o_valid     = (state_q == ST_OUT);
  assign o_ready     = !o_valid || i_res_ready;
  assign o_dbg_state = state_q;

  // Term acceptance, running sum and end-of-sum detection.
  always_comb begin
    accept  = i_valid && o_ready && !i_clr;
    sum     = acc_q + {{GUARD{i_data[WIDTH-1]}}, i_data};
    cnt_inc = o_cnt + CW'(1);
    eos     = accept && (i_last || (cnt_inc == CW'(LEN)));
  end

  // The sum fits WIDTH bits only when bits [AW-1:WIDTH-1] are all equal.
  always_comb begin
    in_range = (sum[AW-1:WIDTH-1] == {(GUARD+1){1'b0}}) ||
               (sum[AW-1:WIDTH-1] == {(GUARD+1){1'b1}});
    pos_ovr  = !in_range && !sum[AW-1];
    neg_ovr  = !in_range &&  sum[AW-1];
`ifdef FADD_ACC_SAT_EN
    if (pos_ovr) begin
      narrow = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (neg_ovr) begin
      narrow = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      narrow = sum[WIDTH-1:0];
    end
`else
    narrow = sum[WIDTH-1:0];
`endif
  end

  // Next state: clear wins; an end of sum always lands in OUT, even
  // back-to-back with a result being consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: if (eos) state_d = ST_OUT;
        ST_OUT: begin
          if (eos)              state_d = ST_OUT;
          else if (i_res_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_ACC;
    else          state_q <= state_d;
  end

  // Partial-sum accumulator and term counter; both restart at end of sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      o_cnt <= '0;
    end else if (i_clr) begin
      acc_q <= '0;
      o_cnt <= '0;
    end else if (eos) begin
      acc_q <= '0;
      o_cnt <= '0;
    end else if (accept) begin
      acc_q <= sum;
      o_cnt <= cnt_inc;
    end
  end

  // Result register: loads only at end of sum, so it holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res <= '0;
      o_ovr <= 1'b0;
    end else if (eos) begin
      o_res <= narrow;
      o_ovr <= pos_ovr || neg_ovr;
    end
  end

  // Sticky overflow: rises together with the flagged result; only clear drops it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      o_ovr_sticky <= 1'b0;
    else if (i_clr)                    o_ovr_sticky <= 1'b0;
    else if (eos && (pos_ovr || neg_ovr)) o_ovr_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_fadd_acc.sv
// Directed bench for fadd_acc with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fadd_acc;

  localparam int WIDTH = 16;
  localparam int LEN   = 8;

  // Clock and reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clr = 1'b0;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             last = 1'b0;
  logic             ready;
  logic             res_valid;
  logic [WIDTH-1:0] res;
  logic             ovr;
  logic             res_ready = 1'b1;
  logic             sticky;
  logic [3:0]       cnt;
  logic             dbg_state;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FADD_ACC_SAT_EN
  localparam logic [15:0] EXP_POS_OVR = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVR = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVR = 16'hE000;
  localparam logic [15:0] EXP_NEG_OVR = 16'h0000;
`endif

  fadd_acc #(.WIDTH(WIDTH), .FRAC(15), .LEN(LEN), .GUARD(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr        (clr),
    .i_valid      (valid),
    .i_data       (data),
    .i_last       (last),
    .o_ready      (ready),
    .o_valid      (res_valid),
    .o_res        (res),
    .o_ovr        (ovr),
    .i_res_ready  (res_ready),
    .o_ovr_sticky (sticky),
    .o_cnt        (cnt),
    .o_dbg_state  (dbg_state)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one term for one edge (caller guarantees o_ready=1).
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    valid = 1'b1;
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},  32'(res_valid), 32'd0);
    check({tag, "_res"},    32'(res),       32'h0);
    check({tag, "_ovr"},    32'(ovr),       32'd0);
    check({tag, "_sticky"}, 32'(sticky),    32'd0);
    check({tag, "_cnt"},    32'(cnt),       32'd0);
    check({tag, "_ready"},  32'(ready),     32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check_reset_vals("post_rst");

    // Plain three-term sum
    send(16'h1000, 1'b0);
    send(16'h2000, 1'b0);
    check("s1_cnt2", 32'(cnt), 32'd2);
    send(16'h0800, 1'b1);
    check("s1_valid", 32'(res_valid), 32'd1);
    check("s1_res",   32'(res),       32'h3800);
    check("s1_ovr",   32'(ovr),       32'd0);
    check("s1_cnt",   32'(cnt),       32'd0);
    check("s1_sticky",32'(sticky),    32'd0);
    tick();
    check("s1_drain", 32'(res_valid), 32'd0);

    // Positive overflow
    send(16'h7000, 1'b0);
    send(16'h7000, 1'b1);
    check("s2_valid", 32'(res_valid), 32'd1);
    check("s2_res",   32'(res),       32'(EXP_POS_OVR));
    check("s2_ovr",   32'(ovr),       32'd1);
    check("s2_sticky",32'(sticky),    32'd1);
    tick();

    // Excursion absorbed by the guard bits
    send(16'h7000, 1'b0);
    send(16'h7000, 1'b0);
    send(16'h9000, 1'b1);
    check("s3_res",   32'(res),       32'h7000);
    check("s3_ovr",   32'(ovr),       32'd0);
    check("s3_sticky",32'(sticky),    32'd1);
    tick();

    // Auto-terminate after LEN terms with a negative overflow
    for (int i = 0; i < LEN - 1; i++) send(16'h8000, 1'b0);
    check("s4_cnt7",  32'(cnt),       32'd7);
    check("s4_nvalid",32'(res_valid), 32'd0);
    send(16'h8000, 1'b0);
    check("s4_valid", 32'(res_valid), 32'd1);
    check("s4_res",   32'(res),       32'(EXP_NEG_OVR));
    check("s4_ovr",   32'(ovr),       32'd1);
    check("s4_cnt",   32'(cnt),       32'd0);
    tick();

    // Backpressure and back-to-back reload
    res_ready = 1'b0;
    send(16'h0010, 1'b1);
    check("bp_valid0", 32'(res_valid), 32'd1);
    check("bp_res0",   32'(res),       32'h0010);
    valid = 1'b1;
    data  = 16'h0020;
    last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(ready),     32'd0);
      check("bp_hold",  32'(res),       32'h0010);
      check("bp_ovr",   32'(ovr),       32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
      tick();
    end
    check("bp_cnt", 32'(cnt), 32'd0);
    res_ready = 1'b1;
    #1;
    check("bp_ready1", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    last  = 1'b0;
    check("b2b_valid", 32'(res_valid), 32'd1);
    check("b2b_res",   32'(res),       32'h0020);
    tick();
    check("b2b_drain", 32'(res_valid), 32'd0);

    // Clear with a term presented in the same cycle
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    check("clr_cnt3", 32'(cnt), 32'd3);
    clr   = 1'b1;
    valid = 1'b1;
    data  = 16'h0100;
    last  = 1'b1;
    tick();
    clr   = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    check("clr_cnt",    32'(cnt),       32'd0);
    check("clr_sticky", 32'(sticky),    32'd0);
    check("clr_valid",  32'(res_valid), 32'd0);
    send(16'h0100, 1'b1);
    check("clr_next_valid", 32'(res_valid), 32'd1);
    check("clr_next_res",   32'(res),       32'h0100);
    check("clr_next_ovr",   32'(ovr),       32'd0);
    tick();

    // Asynchronous reset mid-sum
    send(16'h0123, 1'b0);
    send(16'h0011, 1'b0);
    check("mr_cnt2", 32'(cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    rst_n = 1'b1;
    tick();
    send(16'h0005, 1'b1);
    check("after_rst_res", 32'(res), 32'h0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fadd_acc.md
# fadd_acc

Streaming signed fixed-point accumulator for the adaptive filter tap-sum path. It adds a variable-length sequence of WIDTH-bit two's-complement terms in a guard-extended register and narrows the final sum back to WIDTH bits. Each result carries a per-result overflow flag and feeds a sticky overflow flag. It sits between the tap-product stage and the error/update logic, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, term and result width (signed, two's complement)
- FRAC, 15, fractional bits (Q(WIDTH-FRAC-1).FRAC); documentation only, does not change the arithmetic
- LEN, 8, maximum terms per sum; a sum auto-terminates after LEN accepted terms
- GUARD, 3, accumulator guard bits; accumulator width AW = WIDTH+GUARD; constraint LEN <= 2^GUARD
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_clr  input  1  synchronous clear: aborts the partial sum, drops any pending result, clears the sticky flag
- i_valid  input  1  term valid
- i_data  input  WIDTH  term
- i_last  input  1  term is the final one of the current sum
- o_ready  output  1  term can be accepted
- o_valid  output  1  result valid
- o_res  output  WIDTH  result
- o_ovr  output  1  result out of WIDTH range (qualified by o_valid)
- i_res_ready  input  1  downstream accepts the result
- o_ovr_sticky  output  1  set by any result with o_ovr=1; cleared only by i_clr or reset
- o_cnt  output  $clog2(LEN+1)  terms accepted in the current partial sum

## Operation
- Term accepted when i_valid && o_ready. o_ready = !o_valid || i_res_ready.
- Accumulation: acc <= acc + sign_extend(i_data, AW), computed in AW bits. The accumulator never wraps for sums of up to LEN terms.
- End of sum: an accepted term with i_last=1, or the accepted term that brings o_cnt to LEN.
  - The output register loads narrow(acc + sign_extend(i_data)).
  - acc and o_cnt clear in the same cycle, so the next sum can start on the following cycle.
- Narrowing: with full sum s in AW bits, o_ovr = (s > 2^(WIDTH-1)-1) || (s < -2^(WIDTH-1)). o_res behaviour is set by Configuration.
- o_ovr reflects only the final sum. Intermediate excursions that are absorbed by the guard bits do not flag.
- Output register: o_valid is set at end of sum. It clears on i_res_ready when no new end of sum occurs in that cycle. o_res and o_ovr are held stable while o_valid && !i_res_ready.
- Terms that do not complete a sum may be accepted while a result is pending only if i_res_ready=1, because o_ready is low otherwise.
- FSM, two states:
  - ACC (o_valid=0): go to OUT at end of sum.
  - OUT (o_valid=1): go to ACC on i_res_ready with no end of sum in the same cycle. Stay in OUT on i_res_ready with a simultaneous end of sum; the new result loads back-to-back.
- i_clr has priority over every other event in its cycle:
  - acc, o_cnt, o_valid and o_ovr_sticky clear, and the FSM goes to ACC.
  - A term presented in that cycle is discarded, even if i_valid && o_ready.
- Reset mid-sum or mid-handshake: all state is lost immediately; no partial result is emitted.

## Timing
- Reset values: o_valid=0, o_res=0, o_ovr=0, o_ovr_sticky=0, o_cnt=0, o_ready=1; internally acc=0 and the FSM is in ACC.
- Latency: the result appears on o_valid/o_res/o_ovr one cycle after the clock edge that accepts the final term.
- Throughput: one term per cycle. Back-to-back one-term sums give one result per cycle when i_res_ready=1.
- o_ovr_sticky rises in the same cycle that o_valid presents a result with o_ovr=1.
- o_ready is combinational from o_valid and i_res_ready. No combinational path exists from i_data or i_valid to any output.

## Configuration
- Macro FADD_ACC_SAT_EN.
- Defined: o_res saturates to 2^(WIDTH-1)-1 on positive overflow and to -2^(WIDTH-1) on negative overflow.
- Undefined: o_res = s[WIDTH-1:0] (wrap).
- o_ovr and o_ovr_sticky behave identically in both builds.

## Test plan
All scenarios use WIDTH=16, LEN=8, GUARD=3.
- Terms 0x1000, 0x2000, 0x0800 (last on the third), i_res_ready=1 -> one cycle later o_valid=1, o_res=0x3800, o_ovr=0, o_cnt=0.
- Terms 0x7000, 0x7000 (last) -> o_ovr=1 and o_ovr_sticky=1. o_res=0x7FFF with FADD_ACC_SAT_EN; o_res=0xE000 without.
- Terms 0x7000, 0x7000, 0x9000 (last) -> o_res=0x7000, o_ovr=0 (intermediate excursion absorbed by the guard bits).
- Eight terms of 0x8000 with i_last never asserted -> auto-terminate on the 8th; o_ovr=1; o_res=0x8000 with SAT (0x0000 wrap).
- Backpressure:
  - Stimulus: result pending, i_res_ready=0 for 3 cycles, i_valid=1 with a new term throughout.
  - Response: o_ready=0 and o_res/o_ovr stable for all 3 cycles; the term is accepted in the cycle i_res_ready=1.
  - Back-to-back: a one-term sum completing in that same cycle loads with o_valid staying 1.
- Clear and reset:
  - i_clr after 3 accepted terms with the 4th term presented in the same cycle -> term dropped; o_cnt=0, o_ovr_sticky=0, o_valid=0.
  - The next sum 0x0100 (last) -> o_res=0x0100.
  - i_rst_n low mid-sum -> all outputs return to reset values asynchronously.
